// File: rtl/btb_pkg.sv
// Shared types and sizing helpers for the branch target buffer.
// Default sizes match the core's 32-bit PC and 16-entry table.
package btb_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_ENTRIES = 16;
    localparam int DEF_CTR_W   = 2;

    function automatic int idx_w_of(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int tag_w_of(input int addr_w, input int entries);
        return addr_w - $clog2(entries) - 2;
    endfunction

    localparam int DEF_IDX_W = idx_w_of(DEF_ENTRIES);
    localparam int DEF_TAG_W = tag_w_of(DEF_ADDR_W, DEF_ENTRIES);

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_t;

    typedef struct packed {
        logic                  valid;
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_ADDR_W-1:0] target;
        ctr_t                  ctr;
    } btb_entry_t;

endpackage

// File: rtl/btb_if.sv
// Fetch lookup, execute update, flush and statistics signals of the BTB.
interface btb_if #(parameter int ADDR_W = 32);

    logic [ADDR_W-1:0] if_pc;
    logic              if_hit;
    logic              if_pred_taken;
    logic [ADDR_W-1:0] if_next_pc;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_mispred;
    logic              flush;
    logic [31:0]       stat_lookups;
    logic [31:0]       stat_hits;
    logic [31:0]       stat_mispred;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispred, flush,
        input  if_hit, if_pred_taken, if_next_pc, stat_lookups, stat_hits, stat_mispred
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispred, flush,
        output if_hit, if_pred_taken, if_next_pc, stat_lookups, stat_hits, stat_mispred
    );

endinterface

// File: rtl/btb_sat_counter.sv
// Next-state logic of one CTR_W-bit saturating up/down direction counter.
module btb_sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr,
    input  logic             taken,
    output logic [CTR_W-1:0] ctr_next
);

    localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1'b1);
    localparam logic [CTR_W-1:0] CTR_ZERO = CTR_W'(1'b0);

    // Step towards the resolved direction, holding at either end.
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (&ctr) begin
                ctr_next = ctr;
            end else begin
                ctr_next = ctr + CTR_ONE;
            end
        end else begin
            if (ctr == CTR_ZERO) begin
                ctr_next = ctr;
            end else begin
                ctr_next = ctr - CTR_ONE;
            end
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer: combinational fetch lookup, registered EX update.
// Optional statistics counters are built when BTB_STATS_EN is defined.
module btb_predictor
    import btb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int CTR_W   = DEF_CTR_W
) (
    input  logic  clock,
    input  logic  reset,
    btb_if.slave  bus
);

    localparam int IDX_W = idx_w_of(ENTRIES);
    localparam int TAG_W = tag_w_of(ADDR_W, ENTRIES);
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1'b1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1'b1);

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic [CTR_W-1:0]  ctr;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{
        valid:  1'b0,
        tag:    {TAG_W{1'b0}},
        target: {ADDR_W{1'b0}},
        ctr:    CTR_WNT
    };

    entry_t            table_r [ENTRIES];
    logic [CTR_W-1:0]  ctr_next_s [ENTRIES];
    logic [IDX_W-1:0]  idx_f_s;
    logic [TAG_W-1:0]  tag_f_s;
    entry_t            entry_f_s;
    logic              hit_f_s;
    logic [IDX_W-1:0]  idx_u_s;
    logic [TAG_W-1:0]  tag_u_s;
    entry_t            entry_u_s;
    logic              hit_u_s;
    logic              unused_s;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        btb_sat_counter #(.CTR_W(CTR_W)) u_ctr (
            .ctr      (table_r[g].ctr),
            .taken    (bus.upd_taken),
            .ctr_next (ctr_next_s[g])
        );
    end

    // Fetch lookup; no bypass from a same-cycle update, and masked while in reset.
    always_comb begin
        idx_f_s   = bus.if_pc[IDX_W+1:2];
        tag_f_s   = bus.if_pc[ADDR_W-1:IDX_W+2];
        entry_f_s = table_r[idx_f_s];
        hit_f_s   = ~reset & entry_f_s.valid & (entry_f_s.tag == tag_f_s);
        bus.if_hit        = hit_f_s;
        bus.if_pred_taken = hit_f_s & entry_f_s.ctr[CTR_W-1];
        if (bus.if_pred_taken) begin
            bus.if_next_pc = entry_f_s.target;
        end else begin
            bus.if_next_pc = bus.if_pc + ADDR_W'(3'd4);
        end
    end

    // Tag match for the resolved branch in EX.
    always_comb begin
        idx_u_s   = bus.upd_pc[IDX_W+1:2];
        tag_u_s   = bus.upd_pc[ADDR_W-1:IDX_W+2];
        entry_u_s = table_r[idx_u_s];
        hit_u_s   = entry_u_s.valid & (entry_u_s.tag == tag_u_s);
    end

    // Table state: reset beats flush, flush beats update.
    always_ff @(posedge clock) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (reset) begin
                table_r[i] <= RESET_ENTRY;
            end else if (bus.flush) begin
                table_r[i].valid <= 1'b0;
            end else if (bus.upd_valid && (idx_u_s == IDX_W'(i))) begin
                if (hit_u_s) begin
                    table_r[i].ctr <= ctr_next_s[i];
                    if (bus.upd_taken) begin
                        table_r[i].target <= bus.upd_target;
                    end
                end else if (bus.upd_taken) begin
                    table_r[i].valid  <= 1'b1;
                    table_r[i].tag    <= tag_u_s;
                    table_r[i].target <= bus.upd_target;
                    table_r[i].ctr    <= CTR_WT;
                end
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] lookups_r;
    logic [31:0] hits_r;
    logic [31:0] mispred_r;

    // Wrapping statistics, cleared by reset and by flush.
    always_ff @(posedge clock) begin
        if (reset || bus.flush) begin
            lookups_r <= 32'd0;
            hits_r    <= 32'd0;
            mispred_r <= 32'd0;
        end else begin
            lookups_r <= lookups_r + 32'd1;
            hits_r    <= hits_r + {31'd0, bus.if_hit};
            mispred_r <= mispred_r + {31'd0, bus.upd_valid & bus.upd_mispred};
        end
    end

    assign bus.stat_lookups = lookups_r;
    assign bus.stat_hits    = hits_r;
    assign bus.stat_mispred = mispred_r;
    assign unused_s         = ^bus.upd_pc[1:0];
`else
    assign bus.stat_lookups = 32'd0;
    assign bus.stat_hits    = 32'd0;
    assign bus.stat_mispred = 32'd0;
    assign unused_s         = ^{bus.upd_pc[1:0], bus.upd_mispred};
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor (ENTRIES=16, ADDR_W=32, CTR_W=2).
module tb_btb_predictor;

    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    btb_if #(.ADDR_W(32)) bus ();

    btb_predictor #(.ADDR_W(32), .ENTRIES(16), .CTR_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] target);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_taken  = taken;
        bus.upd_target = target;
        tick();
        bus.upd_valid  = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        bus.if_pc = pc;
        #1;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.if_pc      = 32'h100;
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 32'h100;
        bus.upd_taken  = 1'b1;
        bus.upd_target = 32'h200;
        bus.upd_mispred = 1'b1;
        bus.flush      = 1'b0;
        tick();
        tick();
        checks++; if (bus.if_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %0b want 0", bus.if_hit); end
        checks++; if (bus.if_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred: got %0b want 0", bus.if_pred_taken); end
        checks++; if (bus.if_next_pc !== 32'h104) begin errors++; $display("FAIL reset_next: got %0h want 104", bus.if_next_pc); end
        reset           = 1'b0;
        bus.upd_valid   = 1'b0;
        bus.upd_mispred = 1'b0;
        #1;
        checks++; if (bus.if_hit !== 1'b0) begin errors++; $display("FAIL reset_upd_ignored: got %0b want 0", bus.if_hit); end
        checks++; if (bus.stat_lookups !== 32'd0) begin errors++; $display("FAIL reset_lookups: got %0d want 0", bus.stat_lookups); end
        checks++; if (bus.stat_hits !== 32'd0) begin errors++; $display("FAIL reset_hits: got %0d want 0", bus.stat_hits); end
        checks++; if (bus.stat_mispred !== 32'd0) begin errors++; $display("FAIL reset_mispred: got %0d want 0", bus.stat_mispred); end
    endtask

    task automatic test_allocate();
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 32'h100;
        bus.upd_taken  = 1'b1;
        bus.upd_target = 32'h200;
        look(32'h100);
        checks++; if (bus.if_hit !== 1'b0) begin errors++; $display("FAIL alloc_not_yet: got %0b want 0", bus.if_hit); end
        tick();
        bus.upd_valid = 1'b0;
        look(32'h100);
        checks++; if (bus.if_hit !== 1'b1) begin errors++; $display("FAIL alloc_hit: got %0b want 1", bus.if_hit); end
        checks++; if (bus.if_pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_pred: got %0b want 1", bus.if_pred_taken); end
        checks++; if (bus.if_next_pc !== 32'h200) begin errors++; $display("FAIL alloc_next: got %0h want 200", bus.if_next_pc); end
    endtask

    task automatic test_hysteresis();
        logic        exp_pred [9];
        logic [31:0] exp_next [9];
        logic        tk [9];
        logic [31:0] tgt [9];
        // WT -> WNT -> SNT -> SNT -> WNT -> WT -> ST -> ST -> WT
        tk   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tgt  = '{32'h0, 32'h0, 32'h0, 32'h200, 32'h220, 32'h220, 32'h220, 32'h0, 32'h0};
        exp_pred = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_next = '{32'h104, 32'h104, 32'h104, 32'h104, 32'h220, 32'h220, 32'h220, 32'h220, 32'h104};
        for (int i = 0; i < 9; i++) begin
            do_update(32'h100, tk[i], tgt[i]);
            look(32'h100);
            checks++; if (bus.if_pred_taken !== exp_pred[i]) begin errors++; $display("FAIL hyst_pred[%0d]: got %0b want %0b", i, bus.if_pred_taken, exp_pred[i]); end
            checks++; if (bus.if_next_pc !== exp_next[i]) begin errors++; $display("FAIL hyst_next[%0d]: got %0h want %0h", i, bus.if_next_pc, exp_next[i]); end
        end
        do_update(32'h108, 1'b0, 32'h900);
        look(32'h108);
        checks++; if (bus.if_hit !== 1'b0) begin errors++; $display("FAIL miss_nt_no_alloc: got %0b want 0", bus.if_hit); end
    endtask

    task automatic test_alias();
        do_update(32'h140, 1'b1, 32'h300);
        look(32'h100);
        checks++; if (bus.if_hit !== 1'b0) begin errors++; $display("FAIL alias_old_hit: got %0b want 0", bus.if_hit); end
        look(32'h140);
        checks++; if (bus.if_hit !== 1'b1) begin errors++; $display("FAIL alias_new_hit: got %0b want 1", bus.if_hit); end
        checks++; if (bus.if_next_pc !== 32'h300) begin errors++; $display("FAIL alias_new_next: got %0h want 300", bus.if_next_pc); end
        do_update(32'h140, 1'b0, 32'h0);
        look(32'h140);
        checks++; if (bus.if_pred_taken !== 1'b0) begin errors++; $display("FAIL alias_weak_taken: got %0b want 0", bus.if_pred_taken); end
    endtask

    task automatic test_flush();
        do_update(32'h100, 1'b1, 32'h200);
        look(32'h100);
        checks++; if (bus.if_hit !== 1'b1) begin errors++; $display("FAIL flush_pre_hit: got %0b want 1", bus.if_hit); end
        bus.flush = 1'b1;
        do_update(32'h180, 1'b1, 32'h500);
        bus.flush = 1'b0;
        look(32'h100);
        checks++; if (bus.if_hit !== 1'b0) begin errors++; $display("FAIL flush_0x100: got %0b want 0", bus.if_hit); end
        look(32'h180);
        checks++; if (bus.if_hit !== 1'b0) begin errors++; $display("FAIL flush_0x180: got %0b want 0", bus.if_hit); end
    endtask

    task automatic test_same_cycle();
        do_update(32'h100, 1'b1, 32'h200);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 32'h100;
        bus.upd_taken  = 1'b1;
        bus.upd_target = 32'h400;
        look(32'h100);
        checks++; if (bus.if_next_pc !== 32'h200) begin errors++; $display("FAIL same_cycle_old: got %0h want 200", bus.if_next_pc); end
        tick();
        bus.upd_valid = 1'b0;
        look(32'h100);
        checks++; if (bus.if_next_pc !== 32'h400) begin errors++; $display("FAIL same_cycle_new: got %0h want 400", bus.if_next_pc); end
        look(32'hFFFF_FFFC);
        checks++; if (bus.if_hit !== 1'b0) begin errors++; $display("FAIL wrap_hit: got %0b want 0", bus.if_hit); end
        checks++; if (bus.if_next_pc !== 32'h0) begin errors++; $display("FAIL wrap_next: got %0h want 0", bus.if_next_pc); end
    endtask

    task automatic test_stats();
        logic [31:0] exp_l, exp_h, exp_m;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.if_pc = 32'h100;
        bus.upd_mispred = 1'b1;
        do_update(32'h10C, 1'b0, 32'h0);
        tick();
        bus.upd_mispred = 1'b0;
        tick();
        bus.if_pc = 32'h10C;
        tick();
`ifdef BTB_STATS_EN
        exp_l = 32'd4; exp_h = 32'd0; exp_m = 32'd1;
`else
        exp_l = 32'd0; exp_h = 32'd0; exp_m = 32'd0;
`endif
        // entry 0 was flushed above, so every lookup of 0x100 misses
        checks++; if (bus.stat_lookups !== exp_l) begin errors++; $display("FAIL stat_lookups: got %0d want %0d", bus.stat_lookups, exp_l); end
        checks++; if (bus.stat_hits !== exp_h) begin errors++; $display("FAIL stat_hits: got %0d want %0d", bus.stat_hits, exp_h); end
        checks++; if (bus.stat_mispred !== exp_m) begin errors++; $display("FAIL stat_mispred: got %0d want %0d", bus.stat_mispred, exp_m); end
    endtask

    task automatic test_stat_hits();
        logic [31:0] exp_h;
        do_update(32'h100, 1'b1, 32'h200);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        do_update(32'h100, 1'b1, 32'h200);
        bus.if_pc = 32'h100;
        tick();
        tick();
        tick();
`ifdef BTB_STATS_EN
        exp_h = 32'd3;
`else
        exp_h = 32'd0;
`endif
        checks++; if (bus.stat_hits !== exp_h) begin errors++; $display("FAIL stat_hits_count: got %0d want %0d", bus.stat_hits, exp_h); end
    endtask

    task automatic test_reset_midstream();
        reset          = 1'b1;
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 32'h1C0;
        bus.upd_taken  = 1'b1;
        bus.upd_target = 32'h600;
        tick();
        reset         = 1'b0;
        bus.upd_valid = 1'b0;
        look(32'h1C0);
        checks++; if (bus.if_hit !== 1'b0) begin errors++; $display("FAIL midreset_upd_dropped: got %0b want 0", bus.if_hit); end
        look(32'h100);
        checks++; if (bus.if_hit !== 1'b0) begin errors++; $display("FAIL midreset_cleared: got %0b want 0", bus.if_hit); end
        checks++; if (bus.stat_lookups !== 32'd0) begin errors++; $display("FAIL midreset_lookups: got %0d want 0", bus.stat_lookups); end
    endtask

    initial begin
        reset           = 1'b1;
        bus.if_pc       = 32'h0;
        bus.upd_valid   = 1'b0;
        bus.upd_pc      = 32'h0;
        bus.upd_taken   = 1'b0;
        bus.upd_target  = 32'h0;
        bus.upd_mispred = 1'b0;
        bus.flush       = 1'b0;
        test_reset();
        test_allocate();
        test_hysteresis();
        test_alias();
        test_flush();
        test_same_cycle();
        test_stats();
        test_stat_hits();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
